aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Cycle-accurate sequencer for the iterative AES-128 encryption datapath. Accepts a start pulse, then drives the plaintext/feedback mux, SubBytes capture enable, MixColumns bypass flag, state-register enable and key-schedule step through the initial AddRoundKey plus NUM_ROUNDS rounds. Signals completion with a one-cycle done pulse. Sits between the SPI/host front end and the round datapath (sub_byte, shift_rows, mix_columns, key expansion).

## Interface
- SBOX_LAT, 1: S-box BRAM read latency in cycles; legal 1..4.
- NUM_ROUNDS, 10: number of cipher rounds after the initial AddRoundKey; legal 1..14.

- clk  input  1  system clock; all state changes on rising edge.
- nrst  input  1  asynchronous, active-low reset.
- start  input  1  request one encryption; sampled only in IDLE.
- ready  output  1  high while IDLE.
- busy  output  1  high in LOAD, SUB, MIX.
- done  output  1  one-cycle pulse in DONE.
- input_data_mux  output  1  1 = plaintext into state path, 0 = round feedback.
- sub_byte_en  output  1  captures BRAM S-box output into the sub_byte register.
- mix_columns_flag  output  1  1 = MixColumns applied, 0 = bypassed (final round).
- mixed_data_en  output  1  loads the round-state register.
- key_load  output  1  loads cipher key into key schedule.
- key_step  output  1  advances key schedule by one round key.
- round_num  output  4  current round, 0 = initial AddRoundKey.

## Operation
- States: IDLE, LOAD, SUB, MIX, DONE. Moore outputs, decoded from state/counters only.
- IDLE: ready=1. start=1 -> LOAD, round_num<=0. Otherwise stay.
- LOAD (1 cycle): input_data_mux=1, key_load=1, mixed_data_en=1 (register plaintext XOR key). -> SUB, round_num<=1, lat_cnt<=0.
- SUB (SBOX_LAT cycles): lat_cnt counts 0..SBOX_LAT-1. sub_byte_en=1 only when lat_cnt==SBOX_LAT-1, then -> MIX.
- MIX (1 cycle): mixed_data_en=1, key_step=1, mix_columns_flag=1 iff round_num<NUM_ROUNDS. If round_num==NUM_ROUNDS -> DONE, else -> SUB with round_num+1, lat_cnt<=0.
- DONE (1 cycle): done=1, round_num holds NUM_ROUNDS. -> IDLE, round_num<=0.
- All outputs not listed as active for a state are 0. input_data_mux=0 in all states except LOAD.
- start outside IDLE is ignored (no queuing). start in DONE is ignored; it must be reissued in IDLE.
- round_num never exceeds NUM_ROUNDS; no wrap.

## Timing
- Reset (asynchronous assertion, synchronous-to-clk release): state IDLE, round_num=0, lat_cnt=0. ready=1. All other outputs 0.
- Reset mid-encryption: immediate return to IDLE; no done pulse.
- Edge 0 samples start. LOAD is cycle 1. Round r SUB occupies cycles 2+(r-1)(SBOX_LAT+1) .. 1+(r-1)(SBOX_LAT+1)+SBOX_LAT. MIX follows in the next cycle.
- done is in cycle 2+NUM_ROUNDS(SBOX_LAT+1): 22 at defaults. IDLE follows in the next cycle, so the next start is accepted no earlier than 1 cycle after done.
- key_step pulses exactly NUM_ROUNDS times per operation. key_load pulses exactly once.

## Configuration
- AES_ABORT_EN defined: adds port abort input 1 (synchronous). abort=1 in LOAD/SUB/MIX/DONE -> next state IDLE, round_num<=0, no done. abort has priority over all other transitions. Ignored in IDLE.
- AES_ABORT_EN undefined: abort port absent. An operation always runs to DONE unless nrst is asserted.

## Test plan
- Reset: nrst low with start=1 -> ready=1, round_num=0, all other outputs 0. After release with start=0 -> stays IDLE.
- Default single run: start pulse at edge 0 -> LOAD in cycle 1, done in cycle 22, 10 key_step pulses, 10 sub_byte_en pulses, mix_columns_flag=1 in MIX of rounds 1-9 and 0 in round 10.
- SBOX_LAT=3: sub_byte_en only on the 3rd SUB cycle of each round; done in cycle 42.
- start held high continuously -> runs back-to-back, next LOAD 2 cycles after done; start during busy never restarts the sequence.
- nrst pulsed low during round 5 SUB -> IDLE immediately, no done, next start gives a full 22-cycle run.
- AES_ABORT_EN: abort=1 in round 3 MIX -> IDLE next cycle, round_num=0, no done, no further key_step.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM for an iterative AES-128 encryption datapath.
// Runs the initial AddRoundKey (LOAD) and then NUM_ROUNDS rounds, each made of
// SBOX_LAT SUB cycles and one MIX cycle. A one-cycle DONE state ends the run.
// Parameters: SBOX_LAT (S-box read latency, 1..4), NUM_ROUNDS (1..14).
// Ports: clk, nrst (async active-low reset), start;
//        ready, busy, done, input_data_mux, sub_byte_en, mix_columns_flag,
//        mixed_data_en, key_load, key_step, round_num[3:0].
// Optional macro AES_ABORT_EN adds a synchronous abort input.
module aes_round_sequencer #(
    parameter int SBOX_LAT   = 1,
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
`ifdef AES_ABORT_EN
    input  logic       abort,
`endif
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       input_data_mux,
    output logic       sub_byte_en,
    output logic       mix_columns_flag,
    output logic       mixed_data_en,
    output logic       key_load,
    output logic       key_step,
    output logic [3:0] round_num
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SUB  = 3'd2;
    localparam logic [2:0] MIX  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    localparam logic [1:0] LAT_LAST = 2'(SBOX_LAT - 1);
    localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] lat_cnt;
    logic [1:0] lat_nxt;
    logic [3:0] rnd;
    logic [3:0] rnd_nxt;
    logic       abort_req;

`ifdef AES_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        rnd_nxt   = rnd;
        // Abort wins over every other transition but cannot leave IDLE.
        if (abort_req && (state != IDLE)) begin
            state_nxt = IDLE;
            lat_nxt   = 2'd0;
            rnd_nxt   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = LOAD;
                        rnd_nxt   = 4'd0;
                        lat_nxt   = 2'd0;
                    end
                end
                LOAD: begin
                    state_nxt = SUB;
                    rnd_nxt   = 4'd1;
                    lat_nxt   = 2'd0;
                end
                SUB: begin
                    if (lat_cnt == LAT_LAST) begin
                        state_nxt = MIX;
                    end else begin
                        lat_nxt = lat_cnt + 2'd1;
                    end
                end
                MIX: begin
                    if (rnd == RND_LAST) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = SUB;
                        rnd_nxt   = rnd + 4'd1;
                        lat_nxt   = 2'd0;
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                    rnd_nxt   = 4'd0;
                end
                default: begin
                    state_nxt = IDLE;
                    lat_nxt   = 2'd0;
                    rnd_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
            rnd     <= 4'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            rnd     <= rnd_nxt;
        end
    end

    // Moore decode: outputs depend only on registered state and counters.
    always_comb begin
        ready            = (state == IDLE);
        busy             = (state == LOAD) || (state == SUB) || (state == MIX);
        done             = (state == FIN);
        input_data_mux   = (state == LOAD);
        key_load         = (state == LOAD);
        sub_byte_en      = (state == SUB) && (lat_cnt == LAT_LAST);
        mixed_data_en    = (state == LOAD) || (state == MIX);
        key_step         = (state == MIX);
        // The last round skips MixColumns.
        mix_columns_flag = (state == MIX) && (rnd < RND_LAST);
        round_num        = rnd;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: two instances (SBOX_LAT=1 and 3).
// Stimulus pushes expected per-cycle traces; monitors pop on every non-idle cycle.
module tb_aes_round_sequencer;

    typedef struct {
        int          cyc;
        logic [12:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic nrst0, nrst1, start0, start1;
    logic abort0;
    logic ready0, busy0, done0, mux0, sub0, mcf0, mde0, kl0, ks0;
    logic ready1, busy1, done1, mux1, sub1, mcf1, mde1, kl1, ks1;
    logic [3:0] rn0, rn1;
    logic [12:0] vec0, vec1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_sequencer dut0 (
        .clk(clk), .nrst(nrst0), .start(start0),
`ifdef AES_ABORT_EN
        .abort(abort0),
`endif
        .ready(ready0), .busy(busy0), .done(done0),
        .input_data_mux(mux0), .sub_byte_en(sub0),
        .mix_columns_flag(mcf0), .mixed_data_en(mde0),
        .key_load(kl0), .key_step(ks0), .round_num(rn0)
    );

    aes_round_sequencer #(.SBOX_LAT(3), .NUM_ROUNDS(10)) dut1 (
        .clk(clk), .nrst(nrst1), .start(start1),
`ifdef AES_ABORT_EN
        .abort(1'b0),
`endif
        .ready(ready1), .busy(busy1), .done(done1),
        .input_data_mux(mux1), .sub_byte_en(sub1),
        .mix_columns_flag(mcf1), .mixed_data_en(mde1),
        .key_load(kl1), .key_step(ks1), .round_num(rn1)
    );

    assign vec0 = {ready0, busy0, done0, mux0, sub0, mcf0, mde0, kl0, ks0, rn0};
    assign vec1 = {ready1, busy1, done1, mux1, sub1, mcf1, mde1, kl1, ks1, rn1};

    function automatic logic [12:0] pk(
        input logic r, input logic b, input logic d, input logic m,
        input logic s, input logic f, input logic e, input logic kl,
        input logic ks, input int rn);
        return {r, b, d, m, s, f, e, kl, ks, 4'(rn)};
    endfunction

    task automatic chk(input string nm, input logic ok,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int idx, input int c, input logic [12:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        if (idx == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Expected trace of one encryption whose LOAD cycle is 'load'.
    task automatic push_run(input int idx, input int load, input int lat, input int nr);
        int c = load;
        push(idx, c, pk(0, 1, 0, 1, 0, 0, 1, 1, 0, 0));
        c++;
        for (int r = 1; r <= nr; r++) begin
            for (int l = 0; l < lat; l++) begin
                push(idx, c, pk(0, 1, 0, 0, l == lat - 1, 0, 0, 0, 0, r));
                c++;
            end
            push(idx, c, pk(0, 1, 0, 0, 0, r < nr, 1, 0, 1, r));
            c++;
        end
        push(idx, c, pk(0, 0, 1, 0, 0, 0, 0, 0, 0, nr));
    endtask

    task automatic mon(input int idx, input logic [12:0] act);
        exp_t e;
        int   sz;
        sz = (idx == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            chk($sformatf("mon%0d_unexpected", idx), 1'b0, 32'(act), 32'h1000);
        end else begin
            if (idx == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("mon%0d_cyc", idx), e.cyc == cyc, 32'(cyc), 32'(e.cyc));
            chk($sformatf("mon%0d_out", idx), e.v == act, 32'(act), 32'(e.v));
        end
    endtask

    always @(negedge clk) begin
        if (nrst0 && !ready0) mon(0, vec0);
        if (nrst1 && !ready1) mon(1, vec1);
    end

    task automatic wait_done(input int idx, input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((idx == 0 && done0) || (idx == 1 && done1)) begin
                dc = cyc;
                return;
            end
        end
    endtask

    // Issue one start pulse at a negedge; done must land at a hand-known offset.
    task automatic run_one(input int idx, input int lat, input int done_off, input string nm);
        int c;
        int dc;
        @(negedge clk);
        c = cyc;
        push_run(idx, c + 1, lat, 10);
        if (idx == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(idx, 100, dc);
        chk(nm, dc == c + done_off, 32'(dc - c), 32'(done_off));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int dc;
        nrst0  = 1'b0;
        nrst1  = 1'b0;
        start0 = 1'b1;
        start1 = 1'b1;
        abort0 = 1'b0;

        // Reset with start asserted: outputs stay in the idle pattern.
        repeat (2) @(negedge clk);
        chk("reset_out0", vec0 == 13'h1000, 32'(vec0), 32'h1000);
        chk("reset_out1", vec1 == 13'h1000, 32'(vec1), 32'h1000);
        start0 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        nrst0 = 1'b1;
        nrst1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold0", vec0 == 13'h1000, 32'(vec0), 32'h1000);
        chk("idle_hold1", vec1 == 13'h1000, 32'(vec1), 32'h1000);

        // Single runs: done 22 cycles after the start edge (42 with SBOX_LAT=3).
        run_one(0, 1, 22, "done_cycle_lat1");
        run_one(1, 3, 42, "done_cycle_lat3");

        // Back-to-back with start held high: second LOAD two cycles after done.
        @(negedge clk);
        c = cyc;
        push_run(0, c + 1, 1, 10);
        push_run(0, c + 24, 1, 10);
        start0 = 1'b1;
        wait_done(0, 100, dc);
        chk("b2b_done1", dc == c + 22, 32'(dc - c), 32'd22);
        wait_done(0, 100, dc);
        chk("b2b_done2", dc == c + 45, 32'(dc - c), 32'd45);
        start0 = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset during round 5 SUB (cycle c+10).
        @(negedge clk);
        c = cyc;
        push_run(0, c + 1, 1, 10);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < c + 10) @(posedge clk);
        #2;
        chk("pre_rst_round", rn0 == 4'd5 && busy0, 32'(rn0), 32'd5);
        nrst0 = 1'b0;
        #1;
        chk("mid_rst_out", vec0 == 13'h1000, 32'(vec0), 32'h1000);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        nrst0 = 1'b1;
        repeat (2) @(negedge clk);
        run_one(0, 1, 22, "post_rst_run");

`ifdef AES_ABORT_EN
        // Abort in round 3 MIX (cycle c+7): IDLE next cycle, nothing after.
        @(negedge clk);
        c = cyc;
        push_run(0, c + 1, 1, 10);
        while (q0.size() > 0 && q0[$].cyc > c + 7) void'(q0.pop_back());
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < c + 7) @(posedge clk);
        #2;
        abort0 = 1'b1;
        @(posedge clk);
        #2;
        abort0 = 1'b0;
        chk("abort_idle", vec0 == 13'h1000, 32'(vec0), 32'h1000);
        repeat (30) @(negedge clk);
        run_one(0, 1, 22, "post_abort_run");
`endif

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size() == 0, 32'(q0.size()), 32'd0);
        chk("q1_drained", q1.size() == 0, 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
